// File: rtl/l2_request_controller_if.sv
// Request/response bundle between the processor side, the L2 request controller
// and the cache data-structure block, plus the statistics readout.
interface l2_request_controller_if #(
  parameter int addressBits = 32,
  parameter int tagBits     = 12,
  parameter int indexBits   = 14,
  parameter int offsetBits  = 6,
  parameter int countBits   = 32
);
  logic                   reqValid;
  logic                   reqReady;
  logic                   reqWrite;
  logic [addressBits-1:0] reqAddr;
  logic [indexBits-1:0]   index;
  logic [tagBits-1:0]     addressTag;
  logic                   read;
  logic                   access;
  logic                   respValid;
  logic                   respHit;
  logic                   doneValid;
  logic                   doneHit;
  logic                   doneError;
  logic [offsetBits-1:0]  offset;
  logic                   clearStats;
  logic [countBits-1:0]   readCount;
  logic [countBits-1:0]   writeCount;
  logic [countBits-1:0]   hitCount;
  logic [countBits-1:0]   missCount;
  logic [countBits-1:0]   timeoutCount;

  modport master (
    output reqValid, reqWrite, reqAddr, respValid, respHit, clearStats,
    input  reqReady, index, addressTag, read, access, doneValid, doneHit, doneError,
           offset, readCount, writeCount, hitCount, missCount, timeoutCount
  );

  modport slave (
    input  reqValid, reqWrite, reqAddr, respValid, respHit, clearStats,
    output reqReady, index, addressTag, read, access, doneValid, doneHit, doneError,
           offset, readCount, writeCount, hitCount, missCount, timeoutCount
  );
endinterface

// File: rtl/l2_request_controller.sv
// L2 front-end sequencer: accepts one request, issues a tag/index lookup,
// waits for hit/miss (or timeout), reports completion and keeps saturating stats.
module l2_request_controller #(
  parameter int addressBits   = 32,
  parameter int tagBits       = 12,
  parameter int indexBits     = 14,
  parameter int offsetBits    = 6,
  parameter int countBits     = 32,
  parameter int timeoutCycles = 255
) (
  input logic                  clk,
  input logic                  reset,
  l2_request_controller_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(timeoutCycles - 1);

  state_t                r_state, w_stateNext;
  logic                  r_reqReady, w_reqReadyNext;
  logic                  r_access, w_accessNext;
  logic                  r_doneValid, w_doneValidNext;
  logic                  r_doneHit, w_doneHitNext;
  logic                  r_doneError, w_doneErrorNext;
  logic [7:0]            r_timer, w_timerNext;
  logic                  w_capture;
  logic [tagBits-1:0]    r_addressTag;
  logic [indexBits-1:0]  r_index;
  logic [offsetBits-1:0] r_offset;
  logic                  r_read;
  logic [countBits-1:0]  r_readCount, r_writeCount, r_hitCount, r_missCount, r_timeoutCount;

  function automatic logic [countBits-1:0] sat_inc(input logic [countBits-1:0] v);
    return (&v) ? v : v + {{(countBits-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_reqReady  <= 1'b0;
      r_access    <= 1'b0;
      r_doneValid <= 1'b0;
      r_doneHit   <= 1'b0;
      r_doneError <= 1'b0;
      r_timer     <= '0;
    end else begin
      r_state     <= w_stateNext;
      r_reqReady  <= w_reqReadyNext;
      r_access    <= w_accessNext;
      r_doneValid <= w_doneValidNext;
      r_doneHit   <= w_doneHitNext;
      r_doneError <= w_doneErrorNext;
      r_timer     <= w_timerNext;
    end
  end

  // Next-state and next-output values; every output is registered from these.
  always_comb begin
    w_stateNext     = r_state;
    w_reqReadyNext  = r_reqReady;
    w_accessNext    = 1'b0;
    w_doneValidNext = 1'b0;
    w_doneHitNext   = r_doneHit;
    w_doneErrorNext = r_doneError;
    w_timerNext     = r_timer;
    w_capture       = 1'b0;
    case (r_state)
      IDLE: begin
        w_reqReadyNext = 1'b1;
        if (r_reqReady && bus.reqValid) begin
          w_capture      = 1'b1;
          w_reqReadyNext = 1'b0;
          w_accessNext   = 1'b1;
          w_stateNext    = ISSUE;
        end
      end
      ISSUE: begin
        w_timerNext = '0;
        w_stateNext = WAIT;
      end
      WAIT: begin
        if (bus.respValid) begin
          w_doneHitNext   = bus.respHit;
          w_doneErrorNext = 1'b0;
          w_doneValidNext = 1'b1;
          w_stateNext     = DONE;
        end else if (r_timer == TIMEOUT_LAST) begin
          w_doneHitNext   = 1'b0;
          w_doneErrorNext = 1'b1;
          w_doneValidNext = 1'b1;
          w_stateNext     = DONE;
        end else begin
          w_timerNext = r_timer + 8'd1;
        end
      end
      DONE: begin
        w_reqReadyNext = 1'b1;
        w_stateNext    = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addressTag <= '0;
      r_index      <= '0;
      r_offset     <= '0;
      r_read       <= 1'b0;
    end else if (w_capture) begin
      r_addressTag <= bus.reqAddr[addressBits-1 -: tagBits];
      r_index      <= bus.reqAddr[offsetBits +: indexBits];
      r_offset     <= bus.reqAddr[offsetBits-1:0];
      r_read       <= ~bus.reqWrite;
    end
  end

  // Stats commit on the edge that leaves DONE, so a clear in that cycle wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_readCount    <= '0;
      r_writeCount   <= '0;
      r_hitCount     <= '0;
      r_missCount    <= '0;
      r_timeoutCount <= '0;
    end else if (bus.clearStats) begin
      r_readCount    <= '0;
      r_writeCount   <= '0;
      r_hitCount     <= '0;
      r_missCount    <= '0;
      r_timeoutCount <= '0;
    end else if (r_state == DONE) begin
      if (r_read) r_readCount  <= sat_inc(r_readCount);
      else        r_writeCount <= sat_inc(r_writeCount);
      if (r_doneError)    r_timeoutCount <= sat_inc(r_timeoutCount);
      else if (r_doneHit) r_hitCount     <= sat_inc(r_hitCount);
      else                r_missCount    <= sat_inc(r_missCount);
    end
  end

  assign bus.reqReady     = r_reqReady;
  assign bus.access       = r_access;
  assign bus.doneValid    = r_doneValid;
  assign bus.doneHit      = r_doneHit;
  assign bus.doneError    = r_doneError;
  assign bus.addressTag   = r_addressTag;
  assign bus.index        = r_index;
  assign bus.offset       = r_offset;
  assign bus.read         = r_read;
  assign bus.readCount    = r_readCount;
  assign bus.writeCount   = r_writeCount;
  assign bus.hitCount     = r_hitCount;
  assign bus.missCount    = r_missCount;
  assign bus.timeoutCount = r_timeoutCount;
endmodule

// File: tb/tb_l2_request_controller.sv
// Directed bench for l2_request_controller: 2-bit counters and a 4-cycle timeout
// so saturation and timeout are reachable in a short run.
module tb_l2_request_controller;
  logic clk = 1'b0;
  logic reset;
  int   ncmp = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  l2_request_controller_if #(.countBits(2)) bus ();

  l2_request_controller #(.countBits(2), .timeoutCycles(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_counts(input string tag, input int rd, input int wr, input int hit,
                            input int miss, input int tmo);
    chk({tag, ".readCount"},    32'(bus.readCount),    32'(rd));
    chk({tag, ".writeCount"},   32'(bus.writeCount),   32'(wr));
    chk({tag, ".hitCount"},     32'(bus.hitCount),     32'(hit));
    chk({tag, ".missCount"},    32'(bus.missCount),    32'(miss));
    chk({tag, ".timeoutCount"}, 32'(bus.timeoutCount), 32'(tmo));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".reqReady"},   32'(bus.reqReady),   32'd0);
    chk({tag, ".access"},     32'(bus.access),     32'd0);
    chk({tag, ".doneValid"},  32'(bus.doneValid),  32'd0);
    chk({tag, ".doneHit"},    32'(bus.doneHit),    32'd0);
    chk({tag, ".doneError"},  32'(bus.doneError),  32'd0);
    chk({tag, ".addressTag"}, 32'(bus.addressTag), 32'd0);
    chk({tag, ".index"},      32'(bus.index),      32'd0);
    chk({tag, ".offset"},     32'(bus.offset),     32'd0);
    chk({tag, ".read"},       32'(bus.read),       32'd0);
    chk_counts(tag, 0, 0, 0, 0, 0);
  endtask

  // Full read-hit transaction from IDLE with a response in the first WAIT cycle.
  task automatic read_hit(input logic [31:0] a);
    bus.reqValid = 1'b1; bus.reqWrite = 1'b0; bus.reqAddr = a;
    step();
    bus.reqValid = 1'b0;
    step();
    bus.respValid = 1'b1; bus.respHit = 1'b1;
    step();
    bus.respValid = 1'b0; bus.respHit = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1;
    bus.reqValid = 1'b0; bus.reqWrite = 1'b0; bus.reqAddr = '0;
    bus.respValid = 1'b0; bus.respHit = 1'b0; bus.clearStats = 1'b0;

    // Reset then idle
    step(); step(); step();
    chk_all_zero("rst");
    reset = 1'b0;
    #1;
    chk("rst.readyBeforeEdge", 32'(bus.reqReady), 32'd0);
    step();
    chk("rst.readyAfterEdge", 32'(bus.reqReady), 32'd1);
    chk_counts("rst.idle", 0, 0, 0, 0, 0);

    // Read hit
    bus.reqValid = 1'b1; bus.reqWrite = 1'b0; bus.reqAddr = 32'hABC12345;
    step();
    bus.reqValid = 1'b0;
    chk("rh.access",     32'(bus.access),     32'd1);
    chk("rh.reqReady",   32'(bus.reqReady),   32'd0);
    chk("rh.addressTag", 32'(bus.addressTag), 32'hABC);
    chk("rh.index",      32'(bus.index),      32'h048D);
    chk("rh.offset",     32'(bus.offset),     32'h05);
    chk("rh.read",       32'(bus.read),       32'd1);
    step();
    chk("rh.accessPulse", 32'(bus.access),    32'd0);
    chk("rh.noDoneYet",   32'(bus.doneValid), 32'd0);
    bus.respValid = 1'b1; bus.respHit = 1'b1;
    step();
    bus.respValid = 1'b0; bus.respHit = 1'b0;
    chk("rh.doneValid", 32'(bus.doneValid), 32'd1);
    chk("rh.doneHit",   32'(bus.doneHit),   32'd1);
    chk("rh.doneError", 32'(bus.doneError), 32'd0);
    chk("rh.readyInDone", 32'(bus.reqReady), 32'd0);
    step();
    chk("rh.donePulse", 32'(bus.doneValid), 32'd0);
    chk("rh.readyBack", 32'(bus.reqReady),  32'd1);
    chk("rh.doneHitHeld", 32'(bus.doneHit), 32'd1);
    chk_counts("rh", 1, 0, 1, 0, 0);

    // Write miss, then a read held valid the whole time
    bus.reqValid = 1'b1; bus.reqWrite = 1'b1; bus.reqAddr = 32'h12345678;
    step();
    chk("wm.access",     32'(bus.access),     32'd1);
    chk("wm.read",       32'(bus.read),       32'd0);
    chk("wm.addressTag", 32'(bus.addressTag), 32'h123);
    chk("wm.index",      32'(bus.index),      32'h1159);
    chk("wm.offset",     32'(bus.offset),     32'h38);
    bus.reqWrite = 1'b0; bus.reqAddr = 32'hFEDCBA98;
    step();
    chk("wm.noAccept1", 32'(bus.access), 32'd0);
    bus.respValid = 1'b1; bus.respHit = 1'b0;
    step();
    bus.respValid = 1'b0;
    chk("wm.doneValid", 32'(bus.doneValid), 32'd1);
    chk("wm.doneHit",   32'(bus.doneHit),   32'd0);
    chk("wm.heldTag",   32'(bus.addressTag), 32'h123);
    step();
    chk("wm.noAccept2", 32'(bus.access),   32'd0);
    chk("wm.readyBack", 32'(bus.reqReady), 32'd1);
    chk_counts("wm", 1, 1, 1, 1, 0);
    step();
    bus.reqValid = 1'b0;
    chk("b2b.access",     32'(bus.access),     32'd1);
    chk("b2b.read",       32'(bus.read),       32'd1);
    chk("b2b.addressTag", 32'(bus.addressTag), 32'hFED);
    chk("b2b.index",      32'(bus.index),      32'h32EA);
    step();
    bus.respValid = 1'b1; bus.respHit = 1'b1;
    step();
    bus.respValid = 1'b0; bus.respHit = 1'b0;
    step();
    chk_counts("b2b", 2, 1, 2, 1, 0);

    // Plain clear
    bus.clearStats = 1'b1;
    step();
    bus.clearStats = 1'b0;
    chk_counts("clr", 0, 0, 0, 0, 0);

    // Stray response in IDLE is ignored
    bus.respValid = 1'b1; bus.respHit = 1'b1;
    step();
    bus.respValid = 1'b0; bus.respHit = 1'b0;
    chk("stray.doneValid", 32'(bus.doneValid), 32'd0);
    chk("stray.reqReady",  32'(bus.reqReady),  32'd1);
    step();
    chk_counts("stray", 0, 0, 0, 0, 0);

    // Timeout after exactly 4 WAIT cycles
    bus.reqValid = 1'b1; bus.reqWrite = 1'b0; bus.reqAddr = 32'h00000040;
    step();
    bus.reqValid = 1'b0;
    chk("to.access", 32'(bus.access), 32'd1);
    step();
    step();
    chk("to.wait1", 32'(bus.doneValid), 32'd0);
    step();
    chk("to.wait2", 32'(bus.doneValid), 32'd0);
    step();
    chk("to.wait3", 32'(bus.doneValid), 32'd0);
    step();
    chk("to.doneValid", 32'(bus.doneValid), 32'd1);
    chk("to.doneError", 32'(bus.doneError), 32'd1);
    chk("to.doneHit",   32'(bus.doneHit),   32'd0);
    step();
    chk("to.donePulse", 32'(bus.doneValid), 32'd0);
    chk_counts("to", 1, 0, 0, 0, 1);

    // Clear colliding with the DONE-cycle update
    bus.reqValid = 1'b1; bus.reqWrite = 1'b0; bus.reqAddr = 32'h00000080;
    step();
    bus.reqValid = 1'b0;
    step();
    bus.respValid = 1'b1; bus.respHit = 1'b1;
    step();
    bus.respValid = 1'b0; bus.respHit = 1'b0;
    chk("cc.doneValid", 32'(bus.doneValid), 32'd1);
    chk("cc.doneError", 32'(bus.doneError), 32'd0);
    bus.clearStats = 1'b1;
    step();
    bus.clearStats = 1'b0;
    chk_counts("cc", 0, 0, 0, 0, 0);

    // Saturation of 2-bit counters
    for (int i = 0; i < 5; i++) read_hit(32'h00001000 + 32'(i * 64));
    chk_counts("sat", 3, 0, 3, 0, 0);

    // Reset during WAIT aborts the request
    bus.clearStats = 1'b1;
    step();
    bus.clearStats = 1'b0;
    bus.reqValid = 1'b1; bus.reqWrite = 1'b1; bus.reqAddr = 32'h55555555;
    step();
    bus.reqValid = 1'b0;
    step();
    step();
    reset = 1'b1;
    #1;
    chk_all_zero("abort.inReset");
    step(); step(); step();
    chk_all_zero("abort.held");
    reset = 1'b0;
    bus.respValid = 1'b1; bus.respHit = 1'b1;
    step();
    bus.respValid = 1'b0; bus.respHit = 1'b0;
    chk("abort.reqReady",  32'(bus.reqReady),  32'd1);
    chk("abort.doneValid", 32'(bus.doneValid), 32'd0);
    step();
    chk("abort.noDone", 32'(bus.doneValid), 32'd0);
    chk_counts("abort", 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
